// File: rtl/ps2_scan_receiver_if.sv
// Purpose: bundles the raw PS/2 pins and the decoded scan-code outputs of ps2_scan_receiver.
// Latency: none, wiring only.
// Backpressure: none; the PS/2 bus cannot be stalled and the status outputs are single-cycle pulses.
//
// Signals:
//   PS2Clk, PS2Data   raw keyboard clock/data (asynchronous, idle high)
//   KeyboardCode      last good scan code, held between frames
//   CodeValid         one-cycle pulse, KeyboardCode updated in the same cycle
//   ParityError       one-cycle pulse on an odd-parity failure with a good stop bit
//   FrameError        one-cycle pulse on a bad stop bit or a stalled-frame abort
//   Busy              a frame is in progress
// Modports: master = keyboard side (drives the pins), slave = receiver side.
interface ps2_scan_receiver_if;
    logic       PS2Clk;
    logic       PS2Data;
    logic [7:0] KeyboardCode;
    logic       CodeValid;
    logic       ParityError;
    logic       FrameError;
    logic       Busy;

    modport master (
        output PS2Clk,
        output PS2Data,
        input  KeyboardCode,
        input  CodeValid,
        input  ParityError,
        input  FrameError,
        input  Busy
    );

    modport slave (
        input  PS2Clk,
        input  PS2Data,
        output KeyboardCode,
        output CodeValid,
        output ParityError,
        output FrameError,
        output Busy
    );
endinterface

// File: rtl/ps2_scan_receiver.sv
// Purpose: deserialises the PS/2 keyboard bus into 8-bit scan codes, checking start, odd parity and stop bits.
// Latency: status pulse is registered FILTER_LEN+3 cycles after the stop-bit falling edge at the PS2Clk pin.
// Backpressure: none; every code is reported with a single-cycle CodeValid pulse and must be taken at once.
//
// Ports:
//   Clock  system clock, all state on its rising edge
//   Reset  asynchronous, active-high
//   bus    ps2_scan_receiver_if.slave: PS2Clk/PS2Data in; KeyboardCode, CodeValid,
//          ParityError, FrameError, Busy out
module ps2_scan_receiver #(
    parameter int FILTER_LEN     = 4,      // 2..15 consecutive samples to move the filtered clock
    parameter int TIMEOUT_CYCLES = 50000   // idle cycles mid-frame before the frame is aborted
) (
    input  logic                  Clock,
    input  logic                  Reset,
    ps2_scan_receiver_if.slave    bus
);

    localparam int             TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       FLT_LAST = 4'(FILTER_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Input synchronisers and clock deglitch filter
    logic             clk_sync1_q, clk_sync2_q;
    logic             dat_sync1_q, dat_sync2_q;
    logic             filt_q, filt_d;
    logic             filt_prev_q;
    logic [3:0]       filt_cnt_q, filt_cnt_d;

    // Frame state
    state_t           state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Registered outputs
    logic [7:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;

    logic             fall;
    logic             data_bit;

    assign fall     = filt_prev_q & ~filt_q;
    assign data_bit = dat_sync2_q;

    // The filtered level only moves after FILTER_LEN consecutive disagreeing samples;
    // any sample that matches the current level restarts the count.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = filt_cnt_q;
        if (clk_sync2_q == filt_q) begin
            filt_cnt_d = 4'd0;
        end else if (filt_cnt_q == FLT_LAST) begin
            filt_d     = clk_sync2_q;
            filt_cnt_d = 4'd0;
        end else begin
            filt_cnt_d = filt_cnt_q + 4'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;

        if (state_q == IDLE || fall) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        if (fall) begin
            case (state_q)
                IDLE: begin
                    // A high data bit here is line noise or a residual bit: ignore it.
                    if (!data_bit) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                DATA: begin
                    shift_d   = {data_bit, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = data_bit;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    // Bad stop outranks bad parity; odd parity means XOR over data+parity is 1.
                    if (!data_bit) begin
                        ferr_d = 1'b1;
                    end else if (!(^{shift_q, par_q})) begin
                        perr_d = 1'b1;
                    end else begin
                        code_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && tmo_q == TMO_LAST) begin
            state_d = IDLE;
            ferr_d  = 1'b1;
            tmo_d   = '0;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            clk_sync1_q <= 1'b1;
            clk_sync2_q <= 1'b1;
            dat_sync1_q <= 1'b1;
            dat_sync2_q <= 1'b1;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            filt_cnt_q  <= 4'd0;
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            code_q      <= 8'h00;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            clk_sync1_q <= bus.PS2Clk;
            clk_sync2_q <= clk_sync1_q;
            dat_sync1_q <= bus.PS2Data;
            dat_sync2_q <= dat_sync1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            filt_cnt_q  <= filt_cnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            code_q      <= code_d;
            valid_q     <= valid_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
        end
    end

    assign bus.KeyboardCode = code_q;
    assign bus.CodeValid    = valid_q;
    assign bus.ParityError  = perr_q;
    assign bus.FrameError   = ferr_q;
    assign bus.Busy         = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Purpose: self-checking bench for ps2_scan_receiver, directed scenarios plus random frames.
// Latency: expects status pulses FILTER_LEN+3 cycles after the stop-bit pin edge.
// Backpressure: not applicable; the bench plays the keyboard and counts output pulses.
`timescale 1ns/1ns
module tb_ps2_scan_receiver;

    localparam int FILTER_LEN = 4;
    localparam int TMO        = 100;
    localparam int HALF_BIT   = 20;   // 40 Clock cycles per bit at 2 us Clock = 12.5 kHz bus

    logic Clock;
    logic Reset;

    ps2_scan_receiver_if bus ();

    ps2_scan_receiver #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clock = 1'b0;
    always #1000 Clock = ~Clock;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    always @(posedge Clock) cyc++;

    // Output monitor, sampled away from the active edge
    int n_valid, n_perr, n_ferr, n_multi, n_busy;
    int pulse_cyc;
    int fall_cyc;
    logic [7:0] exp_code;

    always @(negedge Clock) begin
        if (bus.CodeValid === 1'b1)   n_valid++;
        if (bus.ParityError === 1'b1) n_perr++;
        if (bus.FrameError === 1'b1)  n_ferr++;
        if (bus.Busy === 1'b1)        n_busy++;
        if ((32'(bus.CodeValid) + 32'(bus.ParityError) + 32'(bus.FrameError)) > 1) n_multi++;
        if ((bus.CodeValid | bus.ParityError | bus.FrameError) === 1'b1 && pulse_cyc < 0)
            pulse_cyc = cyc;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        n_valid   = 0;
        n_perr    = 0;
        n_ferr    = 0;
        n_multi   = 0;
        n_busy    = 0;
        pulse_cyc = -1;
    endtask

    // start 0, data LSB first, parity (odd unless flipped), stop
    function automatic logic [10:0] make_frame(input logic [7:0] code, input logic par_flip,
                                               input logic stop);
        logic par;
        par = ~(^code) ^ par_flip;
        return {stop, par, code, 1'b0};
    endfunction

    // Plays the first n bits of a frame; data changes mid-high-phase. Ends on a negedge.
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            bus.PS2Data = bits[i];
            repeat (HALF_BIT / 2) @(negedge Clock);
            bus.PS2Clk = 1'b0;
            fall_cyc   = cyc;
            repeat (HALF_BIT) @(negedge Clock);
            bus.PS2Clk = 1'b1;
            repeat (HALF_BIT / 2) @(negedge Clock);
        end
        bus.PS2Data = 1'b1;
    endtask

    // Reference model: outcome decided from the frame's bits alone.
    task automatic run_frame(input string tag, input logic [10:0] fr);
        int ones;
        int e_v, e_p, e_f;
        ones = 0;
        for (int i = 1; i <= 9; i++) ones += int'(fr[i]);
        e_v = 0; e_p = 0; e_f = 0;
        if (fr[10] == 1'b0)      e_f = 1;
        else if (ones % 2 == 0)  e_p = 1;
        else begin
            e_v      = 1;
            exp_code = fr[8:1];
        end
        clear_mon();
        send_bits(fr, 11);
        check_eq({tag, ".valid"}, n_valid, e_v);
        check_eq({tag, ".perr"},  n_perr,  e_p);
        check_eq({tag, ".ferr"},  n_ferr,  e_f);
        check_eq({tag, ".lat"},   pulse_cyc - fall_cyc, FILTER_LEN + 3);
        check_eq({tag, ".code"},  bus.KeyboardCode, exp_code);
        check_eq({tag, ".busy"},  bus.Busy, 0);
        check_eq({tag, ".multi"}, n_multi, 0);
    endtask

    initial begin
        repeat (90000) @(posedge Clock);
        $display("FAIL watchdog: got no finish expected finish before 90000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  rc;
        int          kind;
        logic [10:0] fr;

        Reset       = 1'b1;
        bus.PS2Clk  = 1'b1;
        bus.PS2Data = 1'b1;
        exp_code    = 8'h00;
        clear_mon();
        repeat (3) @(negedge Clock);
        check_eq("rst.code",  bus.KeyboardCode, 8'h00);
        check_eq("rst.valid", bus.CodeValid, 0);
        check_eq("rst.perr",  bus.ParityError, 0);
        check_eq("rst.ferr",  bus.FrameError, 0);
        check_eq("rst.busy",  bus.Busy, 0);
        Reset = 1'b0;
        repeat (10) @(negedge Clock);

        // 1: single good frame
        run_frame("s1_1c", make_frame(8'h1C, 1'b0, 1'b1));

        // 2: back-to-back break prefix then code
        run_frame("s2_f0", make_frame(8'hF0, 1'b0, 1'b1));
        run_frame("s2_1c", make_frame(8'h1C, 1'b0, 1'b1));

        // 3: bad parity
        run_frame("s3_par", make_frame(8'h1C, 1'b1, 1'b1));

        // 4: bad stop with bad parity
        run_frame("s4_stop", make_frame(8'h32, 1'b1, 1'b0));

        // 5: stalled frame aborts on timeout, then a good frame
        clear_mon();
        send_bits(make_frame(8'h32, 1'b0, 1'b1), 5);
        check_eq("s5.busy_mid", bus.Busy, 1);
        repeat (150) @(negedge Clock);
        check_eq("s5.ferr",  n_ferr, 1);
        check_eq("s5.valid", n_valid, 0);
        check_eq("s5.lat",   pulse_cyc - fall_cyc, FILTER_LEN + 3 + TMO);
        check_eq("s5.busy",  bus.Busy, 0);
        check_eq("s5.code",  bus.KeyboardCode, exp_code);
        run_frame("s5_32", make_frame(8'h32, 1'b0, 1'b1));

        // 6a: short low glitch in IDLE with data low
        clear_mon();
        bus.PS2Data = 1'b0;
        bus.PS2Clk  = 1'b0;
        repeat (2) @(negedge Clock);
        bus.PS2Clk  = 1'b1;
        repeat (30) @(negedge Clock);
        bus.PS2Data = 1'b1;
        check_eq("s6a.busy",   n_busy, 0);
        check_eq("s6a.pulses", n_valid + n_perr + n_ferr, 0);

        // 6b: asynchronous reset mid-frame
        send_bits(make_frame(8'h1C, 1'b0, 1'b1), 6);
        check_eq("s6b.busy_mid", bus.Busy, 1);
        #300;
        Reset = 1'b1;
        #1;
        check_eq("s6b.code",  bus.KeyboardCode, 8'h00);
        check_eq("s6b.busy",  bus.Busy, 0);
        check_eq("s6b.flags", {bus.CodeValid, bus.ParityError, bus.FrameError}, 3'b000);
        exp_code = 8'h00;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        repeat (10) @(negedge Clock);
        run_frame("s6b_1c", make_frame(8'h1C, 1'b0, 1'b1));

        // Random frames: good, bad parity, bad stop (with random parity)
        for (int k = 0; k < 14; k++) begin
            rc   = 8'($urandom_range(0, 255));
            kind = int'($urandom_range(0, 3));
            case (kind)
                2:       fr = make_frame(rc, 1'b1, 1'b1);
                3:       fr = make_frame(rc, 1'($urandom_range(0, 1)), 1'b0);
                default: fr = make_frame(rc, 1'b0, 1'b1);
            endcase
            run_frame($sformatf("rnd%0d", k), fr);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
